cnn_frame_tx: RTL

Initiator for the CNN accelerator's serial input protocol. A host loads one frame into an internal 45-word buffer: a 6×6 feature map followed by a 3×3 kernel, 16-bit signed. On `start`, the block streams the frame to the CNN over `cnn_in_valid`/`cnn_in_data`/`cnn_opt`. It then collects the four pooled results returned on `cnn_out_valid`/`cnn_out_data` and presents them to the host as one packed word.

---
 rtl/cnn_tx_pkg.sv | 23 ++
 rtl/cnn_tx_buf.sv | 23 ++
 rtl/cnn_frame_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cnn_tx_pkg.sv
// Shared types and sizes for the CNN frame initiator.
package cnn_tx_pkg;

  localparam int DATA_W    = 16;
  localparam int FMAP_LEN  = 36;
  localparam int KERN_LEN  = 9;
  localparam int FRAME_LEN = FMAP_LEN + KERN_LEN;
  localparam int RES_LEN   = 4;
  localparam int ADDR_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } state_t;

  function automatic logic addr_in_frame(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(FRAME_LEN);
  endfunction

endpackage

// File: rtl/cnn_tx_buf.sv
// Frame buffer: 45 x 16 register array, synchronous write, combinational read.
module cnn_tx_buf
  import cnn_tx_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (wr_en && addr_in_frame(wr_addr)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = addr_in_frame(rd_addr) ? mem[rd_addr] : '0;

endmodule

// File: rtl/cnn_frame_tx.sv
// Streams a buffered fmap+kernel frame to the CNN and packs its 4 pooled results.
// Optional response timeout enabled by defining CNN_FRAME_TX_TIMEOUT_EN.
module cnn_frame_tx
  import cnn_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      start,
  input  logic                      opt_in,
  output logic                      busy,
  output logic                      cnn_in_valid,
  output logic [DATA_W-1:0]         cnn_in_data,
  output logic                      cnn_opt,
  input  logic                      cnn_out_valid,
  input  logic [DATA_W-1:0]         cnn_out_data,
  output logic                      res_valid,
  output logic [RES_LEN*DATA_W-1:0] res_data,
  output logic                      timeout
);

  state_t state_reg, state_next;
  // send_cnt holds the address of the next word to place on the bus
  logic [ADDR_W-1:0] send_cnt_reg, send_cnt_next;
  logic [1:0]        idx_reg, idx_next;
  logic              opt_reg, opt_next;
  logic              in_valid_reg, in_valid_next;
  logic [DATA_W-1:0] in_data_reg, in_data_next;
  logic [RES_LEN-1:0][DATA_W-1:0] res_reg, res_next;

  logic              buf_wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] first_word;
  logic              last_capture;
  logic              timeout_hit;

  assign buf_wr_en = wr_en && (state_reg == ST_IDLE);
  assign rd_addr   = (state_reg == ST_SEND) ? send_cnt_reg : '0;
  // A write to word 0 in the start cycle lands too late for the array read.
  assign first_word   = (buf_wr_en && wr_addr == '0) ? wr_data : rd_data;
  assign last_capture = (state_reg == ST_RECV) && cnn_out_valid &&
                        (idx_reg == 2'(RES_LEN - 1));

  cnn_tx_buf u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      send_cnt_reg <= '0;
      idx_reg      <= '0;
      opt_reg      <= 1'b0;
      in_valid_reg <= 1'b0;
      in_data_reg  <= '0;
      res_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      send_cnt_reg <= send_cnt_next;
      idx_reg      <= idx_next;
      opt_reg      <= opt_next;
      in_valid_reg <= in_valid_next;
      in_data_reg  <= in_data_next;
      res_reg      <= res_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    send_cnt_next = send_cnt_reg;
    idx_next      = idx_reg;
    opt_next      = opt_reg;
    in_valid_next = in_valid_reg;
    in_data_next  = in_data_reg;
    res_next      = res_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_SEND;
          opt_next      = opt_in;
          in_valid_next = 1'b1;
          in_data_next  = first_word;
          send_cnt_next = ADDR_W'(1);
        end
      end
      ST_SEND: begin
        if (send_cnt_reg == ADDR_W'(FRAME_LEN)) begin
          state_next    = ST_WAIT;
          in_valid_next = 1'b0;
          in_data_next  = '0;
          opt_next      = 1'b0;
        end else begin
          in_data_next  = rd_data;
          send_cnt_next = send_cnt_reg + ADDR_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnn_out_valid) begin
          res_next[0] = cnn_out_data;
          idx_next    = 2'd1;
          state_next  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (cnn_out_valid) begin
          res_next[idx_reg] = cnn_out_data;
          idx_next          = idx_reg + 2'd1;
          if (last_capture) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (timeout_hit && !last_capture) begin
      state_next = ST_IDLE;
    end
  end

`ifdef CNN_FRAME_TX_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_reg;
  logic              waiting;

  assign waiting = (state_reg == ST_WAIT) || (state_reg == ST_RECV);
  // Counter is 0 in the first WAIT cycle; the pulse lands TIMEOUT_CYCLES after the last word.
  assign timeout_hit = waiting && (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= timeout_hit && !last_capture;
      if (waiting) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  logic cfg_unused;
  assign cfg_unused  = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign busy         = (state_reg != ST_IDLE);
  assign cnn_in_valid = in_valid_reg;
  assign cnn_in_data  = in_data_reg;
  assign cnn_opt      = opt_reg;
  assign res_valid    = (state_reg == ST_DONE);
  assign res_data     = res_reg;

endmodule
